cpu_run_ctrl: RTL and testbench

//  Synthesizable run controller for top_cpu. It sequences the core reset, counts execution cycles,
//  and detects end-of-test: a write to a magic address, a PC self-loop halt, or a timeout.

---
 rtl/cpu_run_ctrl_if.sv | 21 ++
 rtl/cpu_run_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Core-side signals seen by the run controller: fetch PC, data-memory store port,
// and the reset the controller drives back into the core.
interface cpu_run_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] pc_i;
    logic            mem_we_i;
    logic [31:0]     mem_addr_i;
    logic [31:0]     mem_wdata_i;
    logic            cpu_rst_o;

    // master = core side, slave = run controller
    modport master (
        output pc_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  cpu_rst_o
    );
    modport slave (
        input  pc_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output cpu_rst_o
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for top_cpu: sequences core reset, counts RUN cycles and detects
// end-of-test by magic store, PC self-loop halt or timeout. All outputs registered.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned STALL_LIMIT = 4,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_FFFC,
    parameter logic [31:0] PASS_VAL    = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    cpu_run_ctrl_if.slave    core,
    output logic             running_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             halt_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycles_o
);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]     stall_q, stall_d, stall_nxt;
    logic [PC_W-1:0]   pc_prev_q, pc_prev_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  cyc_d;
    logic              done_d, pass_d, halt_d, to_d;
    logic              cpu_rst_d, running_d;
    logic              store_hit;

    assign store_hit = core.mem_we_i && (core.mem_addr_i == DONE_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rst_cnt_q      <= '0;
            stall_q        <= '0;
            pc_prev_q      <= '0;
            first_q        <= 1'b0;
            cycles_o       <= '0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            halt_o         <= 1'b0;
            timeout_o      <= 1'b0;
            core.cpu_rst_o <= 1'b1;
            running_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            stall_q        <= stall_d;
            pc_prev_q      <= pc_prev_d;
            first_q        <= first_d;
            cycles_o       <= cyc_d;
            done_o         <= done_d;
            pass_o         <= pass_d;
            halt_o         <= halt_d;
            timeout_o      <= to_d;
            core.cpu_rst_o <= cpu_rst_d;
            running_o      <= running_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stall_d   = stall_q;
        pc_prev_d = pc_prev_q;
        first_d   = first_q;
        cyc_d     = cycles_o;
        done_d    = done_o;
        pass_d    = pass_o;
        halt_d    = halt_o;
        to_d      = timeout_o;
        stall_nxt = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RESET;
                    rst_cnt_d = RW'(RST_CYCLES);
                    stall_d   = '0;
                    pc_prev_d = '0;
                    first_d   = 1'b1;
                    cyc_d     = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    halt_d    = 1'b0;
                    to_d      = 1'b0;
                end
            end
            RESET: begin
                if (rst_cnt_q <= RW'(1)) state_d = RUN;
                else                     rst_cnt_d = rst_cnt_q - RW'(1);
            end
            RUN: begin
                cyc_d = cycles_o + CNT_W'(1);
                // first RUN cycle only seeds pc_prev; a stale PC from a prior run must not count
                if (!first_q && (core.pc_i == pc_prev_q)) stall_nxt = stall_q + SW'(1);
                stall_d   = stall_nxt;
                pc_prev_d = core.pc_i;
                first_d   = 1'b0;
                // priority: store beats halt beats timeout, so exactly one cause flag is set
                if (store_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (core.mem_wdata_i == PASS_VAL);
                end else if (stall_nxt == SW'(STALL_LIMIT)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    halt_d  = 1'b1;
                end else if (cyc_d == CNT_W'(TIMEOUT)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // registered versions track the state being entered so they align with it
        cpu_rst_d = (state_d != RUN);
        running_d = (state_d == RUN);
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: two instances (default timeout and TIMEOUT=20)
// share stimulus; run outcomes are scoreboarded and compared when done_o rises.
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pc = '0, addr = '0, wdata = '0;
    logic        we = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.PC_W(32)) ifa ();
    cpu_run_ctrl_if #(.PC_W(32)) ifb ();
    assign ifa.pc_i = pc;  assign ifa.mem_we_i = we;
    assign ifa.mem_addr_i = addr;  assign ifa.mem_wdata_i = wdata;
    assign ifb.pc_i = pc;  assign ifb.mem_we_i = we;
    assign ifb.mem_addr_i = addr;  assign ifb.mem_wdata_i = wdata;

    logic        run_v [2], done_v [2], pass_v [2], halt_v [2], to_v [2], cr_v [2];
    logic [31:0] cyc_v [2];
    assign cr_v[0] = ifa.cpu_rst_o;
    assign cr_v[1] = ifb.cpu_rst_o;

    cpu_run_ctrl #(.TIMEOUT(100000)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .core(ifa.slave),
        .running_o(run_v[0]), .done_o(done_v[0]), .pass_o(pass_v[0]),
        .halt_o(halt_v[0]), .timeout_o(to_v[0]), .cycles_o(cyc_v[0]));

    cpu_run_ctrl #(.TIMEOUT(20)) u_to (
        .clk(clk), .rst(rst), .start_i(start), .core(ifb.slave),
        .running_o(run_v[1]), .done_o(done_v[1]), .pass_o(pass_v[1]),
        .halt_o(halt_v[1]), .timeout_o(to_v[1]), .cycles_o(cyc_v[1]));

    typedef struct {
        string       tag;
        int          sel;
        logic        pass;
        logic        halt;
        logic        to;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse start from IDLE/DONE; status must clear on RESET entry, RUN must follow
    task automatic start_run(input int sel);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_done_clr", 32'(done_v[sel]), 0);
        chk("restart_cyc_clr", cyc_v[sel], 0);
        chk("restart_cpu_rst", 32'(cr_v[sel]), 1);
        for (int i = 0; i < 8 && run_v[sel] !== 1'b1; i++) @(negedge clk);
        chk("restart_running", 32'(run_v[sel]), 1);
    endtask

    // drive RUN cycles until the selected DUT reports done, then pop and compare
    task automatic drive_run(input int sel, input int store_at, input logic [31:0] sdata,
                             input int stick_at, input int maxc);
        int   k;
        logic seen;
        exp_t e;
        k = 1;
        seen = 1'b0;
        while (k <= maxc && !seen) begin
            pc    = (stick_at != 0 && k >= stick_at) ? 32'h40 : 32'h100 + 32'(4 * k);
            we    = (k == store_at);
            addr  = 32'hFFFC;
            wdata = sdata;
            @(negedge clk);
            seen = done_v[sel];
            k++;
        end
        we = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_done"}, 32'(seen), 1);
        chk({e.tag, "_pass"}, 32'(pass_v[e.sel]), 32'(e.pass));
        chk({e.tag, "_halt"}, 32'(halt_v[e.sel]), 32'(e.halt));
        chk({e.tag, "_timeout"}, 32'(to_v[e.sel]), 32'(e.to));
        chk({e.tag, "_cycles"}, cyc_v[e.sel], e.cyc);
        chk({e.tag, "_cpu_rst"}, 32'(cr_v[e.sel]), 1);
        chk({e.tag, "_running"}, 32'(run_v[e.sel]), 0);
    endtask

    initial begin
        // T1: reset values and reset-sequencing timing
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", 32'(cr_v[0]), 1);
        chk("rst_running", 32'(run_v[0]), 0);
        chk("rst_done", 32'(done_v[0]), 0);
        chk("rst_flags", {29'd0, pass_v[0], halt_v[0], to_v[0]}, 0);
        chk("rst_cycles", cyc_v[0], 0);
        rst = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("t1_reset_c1_cpu_rst", 32'(cr_v[0]), 1);
        chk("t1_reset_c1_running", 32'(run_v[0]), 0);
        @(negedge clk);
        chk("t1_reset_c2_cpu_rst", 32'(cr_v[0]), 1);
        chk("t1_reset_c2_running", 32'(run_v[0]), 0);
        @(negedge clk);
        chk("t1_run_cpu_rst", 32'(cr_v[0]), 0);
        chk("t1_run_running", 32'(run_v[0]), 1);

        // T2: pass store on RUN cycle 50
        sb.push_back('{"T2", 0, 1'b1, 1'b0, 1'b0, 32'd50});
        drive_run(0, 50, 32'h1, 0, 60);
        repeat (3) @(negedge clk);
        chk("t2_cycles_held", cyc_v[0], 50);
        chk("t2_done_held", 32'(done_v[0]), 1);

        // T3: fail store sets done only; stores outside RUN are ignored
        start_run(0);
        sb.push_back('{"T3", 0, 1'b0, 1'b0, 1'b0, 32'd5});
        drive_run(0, 5, 32'h0, 0, 20);
        we = 1'b1; addr = 32'hFFFC; wdata = 32'h1;
        repeat (2) @(negedge clk);
        we = 1'b0;
        chk("t3_store_in_done_pass", 32'(pass_v[0]), 0);
        chk("t3_store_in_done_cycles", cyc_v[0], 5);

        // T4: PC stuck from cycle 10 -> halt after 4 equal compares
        start_run(0);
        sb.push_back('{"T4", 0, 1'b0, 1'b1, 1'b0, 32'd14});
        drive_run(0, 0, 32'h0, 10, 40);

        // T5: pass store coinciding with timeout wins; then pure timeout
        start_run(1);
        sb.push_back('{"T5_pass_wins", 1, 1'b1, 1'b0, 1'b0, 32'd20});
        drive_run(1, 20, 32'h1, 0, 30);
        start_run(1);
        sb.push_back('{"T5_timeout", 1, 1'b0, 1'b0, 1'b1, 32'd20});
        drive_run(1, 0, 32'h0, 0, 30);

        // T6: async reset mid-RUN on the long-timeout instance, then a clean rerun
        chk("t6_still_running", 32'(run_v[0]), 1);
        rst = 1'b0;
        #2;
        chk("t6_async_cpu_rst", 32'(cr_v[0]), 1);
        chk("t6_async_running", 32'(run_v[0]), 0);
        @(negedge clk);
        chk("t6_status_cleared", {27'd0, done_v[0], pass_v[0], halt_v[0], to_v[0], run_v[0]}, 0);
        chk("t6_cycles_cleared", cyc_v[0], 0);
        chk("t6_to_inst_cleared", {28'd0, done_v[1], pass_v[1], halt_v[1], to_v[1]}, 0);
        rst = 1'b1;
        start_run(0);
        sb.push_back('{"T6_rerun", 0, 1'b1, 1'b0, 1'b0, 32'd3});
        drive_run(0, 3, 32'h1, 0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
